clint_timer: RTL and testbench
==============================

CLINT_TIMER -- requirements
Module: clint_timer

Interface
REQ-001 Parameter BASE_ADR, default 32'h0200_0000, block base address; the block decodes data_adr[31:16] == BASE_ADR[31:16].
REQ-002 Parameter PRESCALE, default 1, clk cycles per mtime increment (legal range 1..65535).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 mem_read  in  1  load request from the core memory stage.
REQ-006 mem_write  in  1  store request from the core memory stage.
REQ-007 data_out_mask  in  4  byte enables for stores; bit i enables byte i.
REQ-008 data_adr  in  32  byte address.
REQ-009 data_out  in  32  store data from the core.
REQ-010 ext_irq_async  in  1  asynchronous external interrupt line.
REQ-011 rd_data  out  32  combinational read data, 0 when no read hit.
REQ-012 rd_hit  out  1  combinational; mem_read and address in block range, for the external data_in mux.
REQ-013 machine_software_interrupt  out  1  registered msip[0].
REQ-014 machine_timer_interrupt  out  1  registered (mtime >= mtimecmp).
REQ-015 machine_external_interrupt  out  1  ext_irq_async after a 2-flop synchronizer.

Function
REQ-016 Register map (offset = data_adr[15:0], word aligned; data_adr[1:0] ignored): 0x0000 msip (bit 0 only, other bits read 0), 0x4000 mtimecmp[31:0], 0x4004 mtimecmp[63:32], 0xBFF8 mtime[31:0], 0xBFFC mtime[63:32].
REQ-017 In-range unmapped offsets: read 0, writes ignored; out-of-range accesses: rd_hit=0, no state change.
REQ-018 Writes take effect at the clk edge ending the mem_write cycle; only bytes with data_out_mask=1 are updated.
REQ-019 Prescaler: 16-bit counter tick_cnt counts 0..PRESCALE-1 and wraps; tick is asserted in the cycle tick_cnt == PRESCALE-1 (every cycle when PRESCALE=1).
REQ-020 On tick, mtime <= mtime + 1, 64-bit, wrapping 0xFFFF_FFFF_FFFF_FFFF -> 0 with full carry from low to high word.
REQ-021 Simultaneous tick and mtime write: the written bytes take the written value; unwritten bytes of the addressed word keep the old value (no increment applied to that word); the other word increments normally, including carry from the low word.
REQ-022 A write to either mtime word resets tick_cnt to 0.
REQ-023 machine_timer_interrupt updates every cycle from the 64-bit unsigned compare of the current register values, giving 1-cycle latency after the mtime/mtimecmp change.
REQ-024 Writing mtimecmp to a value greater than mtime deasserts machine_timer_interrupt on the following cycle; there is no sticky state.
REQ-025 machine_software_interrupt follows msip[0] with 1-cycle register latency after the write edge.
REQ-026 machine_external_interrupt lags ext_irq_async by 2 rising edges; no edge detection (level).
REQ-027 Reads return current register contents combinationally (pre-edge value in the same cycle as a write to the same register).
REQ-028 mem_read and mem_write both asserted: the write is performed and rd_data shows pre-write data.

Reset
REQ-029 While rst=0: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, tick_cnt=0, sync flops=0, all three interrupt outputs=0.
REQ-030 Reset asserted mid-operation clears all state immediately (asynchronously), regardless of clk; first increment occurs PRESCALE cycles after rst rises.

Verification
REQ-031 PRESCALE=4, release reset, run 40 cycles -> mtime=10, read 0xBFF8 returns 10, machine_timer_interrupt=0.
REQ-032 Write mtimecmp lo=20, hi=0 (PRESCALE=1), mtime at 0 -> interrupt rises exactly 1 cycle after mtime reaches 20; then write mtimecmp lo=100 -> interrupt low next cycle.
REQ-033 Write mtime lo=FFFF_FFFF, hi=0 -> after one tick, reads lo=0, hi=1; byte write mask 4'b0001 data 0xAA to mtime lo during a tick -> only byte 0 = 0xAA, no increment on that word.
REQ-034 Store 1 to 0x0000 -> machine_software_interrupt=1 next cycle; read returns 1; store 0xFFFF_FFFE -> output 0, read returns 0.
REQ-035 Pulse ext_irq_async high for 3 cycles -> machine_external_interrupt high for 3 cycles, delayed 2 edges; access at BASE_ADR+0x1_0000 -> rd_hit=0, no state change.
REQ-036 Assert rst mid-count with interrupts active -> all outputs 0 and mtime reads 0 without a clk edge.

Source files
------------

// File: rtl/clint_timer.sv
// clint_timer: core-local interruptor with a memory-mapped 64-bit machine timer.
//
// Ports
//   clk                        single clock, all state updates on the rising edge
//   rst                        asynchronous, active-low reset
//   mem_read, mem_write        load/store request from the core memory stage
//   data_out_mask[3:0]         store byte enables (bit i enables byte i)
//   data_adr[31:0]             byte address; block hits when [31:16] == BASE_ADR[31:16]
//   data_out[31:0]             store data
//   ext_irq_async              asynchronous external interrupt line
//   rd_data[31:0]              combinational read data, 0 when no read hit
//   rd_hit                     combinational read hit, steers the core's data_in mux
//   machine_software_interrupt registered msip[0]
//   machine_timer_interrupt    registered (mtime >= mtimecmp)
//   machine_external_interrupt ext_irq_async after a two-flop synchronizer
//
// Access semantics: there is no handshake. A request is accepted in the cycle
// it is presented. Reads are answered combinationally in that same cycle with
// the pre-edge register contents; writes commit at the rising edge that ends
// the cycle. A cycle with both mem_read and mem_write performs the write and
// returns the pre-write value.
//
// Register map (offset = data_adr[15:0], data_adr[1:0] ignored):
//   0x0000 msip (bit 0), 0x4000/0x4004 mtimecmp lo/hi, 0xBFF8/0xBFFC mtime lo/hi

module clint_timer #(
  parameter logic [31:0] BASE_ADR = 32'h0200_0000,
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  data_out_mask,
  input  logic [31:0] data_adr,
  input  logic [31:0] data_out,
  input  logic        ext_irq_async,
  output logic [31:0] rd_data,
  output logic        rd_hit,
  output logic        machine_software_interrupt,
  output logic        machine_timer_interrupt,
  output logic        machine_external_interrupt
);

  localparam logic [15:0] OFF_MSIP    = 16'h0000;
  localparam logic [15:0] OFF_CMP_LO  = 16'h4000;
  localparam logic [15:0] OFF_CMP_HI  = 16'h4004;
  localparam logic [15:0] OFF_TIME_LO = 16'hBFF8;
  localparam logic [15:0] OFF_TIME_HI = 16'hBFFC;
  localparam logic [15:0] TICK_LAST   = 16'(PRESCALE - 1);

  logic [15:0] tick_cnt;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;
  logic        sync_a;
  logic        sync_b;
  logic        mti_q;
  logic        msi_q;

  logic        in_range;
  logic [15:0] offset;
  logic        wr_en;
  logic        we_msip;
  logic        we_cmp_lo;
  logic        we_cmp_hi;
  logic        we_time_lo;
  logic        we_time_hi;
  logic        tick;
  logic [63:0] mtime_inc;
  logic [63:0] mtime_next;

  // Byte offset bits are don't-care for word-aligned registers.
  logic unused_adr_bits;
  assign unused_adr_bits = ^data_adr[1:0];

  // Byte-lane merge of store data into an existing word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return res;
  endfunction

  always_comb begin
    in_range   = (data_adr[31:16] == BASE_ADR[31:16]);
    offset     = {data_adr[15:2], 2'b00};
    wr_en      = mem_write && in_range;
    we_msip    = wr_en && (offset == OFF_MSIP);
    we_cmp_lo  = wr_en && (offset == OFF_CMP_LO);
    we_cmp_hi  = wr_en && (offset == OFF_CMP_HI);
    we_time_lo = wr_en && (offset == OFF_TIME_LO);
    we_time_hi = wr_en && (offset == OFF_TIME_HI);
    tick       = (tick_cnt == TICK_LAST);
  end

  // A written mtime word takes the merged store value and skips the increment;
  // the other word still advances, including the carry out of the old low word.
  always_comb begin
    mtime_inc  = mtime + 64'd1;
    mtime_next = tick ? mtime_inc : mtime;
    if (we_time_lo) mtime_next[31:0]  = merge_bytes(mtime[31:0], data_out, data_out_mask);
    if (we_time_hi) mtime_next[63:32] = merge_bytes(mtime[63:32], data_out, data_out_mask);
  end

  always_comb begin
    rd_hit  = mem_read && in_range;
    rd_data = 32'd0;
    if (rd_hit) begin
      case (offset)
        OFF_MSIP:    rd_data = {31'd0, msip};
        OFF_CMP_LO:  rd_data = mtimecmp[31:0];
        OFF_CMP_HI:  rd_data = mtimecmp[63:32];
        OFF_TIME_LO: rd_data = mtime[31:0];
        OFF_TIME_HI: rd_data = mtime[63:32];
        default:     rd_data = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= 16'd0;
      mtime    <= 64'd0;
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip     <= 1'b0;
      sync_a   <= 1'b0;
      sync_b   <= 1'b0;
      mti_q    <= 1'b0;
      msi_q    <= 1'b0;
    end else begin
      // Any mtime store restarts the prescaler so the next increment is a full
      // PRESCALE period after the store.
      if (we_time_lo || we_time_hi) tick_cnt <= 16'd0;
      else if (tick)                tick_cnt <= 16'd0;
      else                          tick_cnt <= tick_cnt + 16'd1;

      mtime <= mtime_next;

      if (we_cmp_lo) mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], data_out, data_out_mask);
      if (we_cmp_hi) mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], data_out, data_out_mask);

      if (we_msip && data_out_mask[0]) msip <= data_out[0];

      sync_a <= ext_irq_async;
      sync_b <= sync_a;

      // Level compare of the current registers; no sticky state.
      mti_q <= (mtime >= mtimecmp);
      msi_q <= msip;
    end
  end

  assign machine_software_interrupt = msi_q;
  assign machine_timer_interrupt    = mti_q;
  assign machine_external_interrupt = sync_b;

endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: directed and randomized bench for clint_timer. Two instances
// (PRESCALE=1 and PRESCALE=4) share one stimulus stream; a behavioural model
// tracks the architectural state of each and every cycle is compared.

module tb_clint_timer;

  localparam int unsigned P_FAST = 1;
  localparam int unsigned P_SLOW = 4;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        mem_read  = 1'b0;
  logic        mem_write = 1'b0;
  logic [3:0]  mask      = 4'h0;
  logic [31:0] adr       = 32'h0;
  logic [31:0] wdata     = 32'h0;
  logic        ext       = 1'b0;

  logic [31:0] rdat [2];
  logic [1:0]  rhit;
  logic [1:0]  msi_o;
  logic [1:0]  mti_o;
  logic [1:0]  mei_o;

  clint_timer #(.BASE_ADR(32'h0200_0000), .PRESCALE(P_FAST)) u_fast (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .data_out_mask(mask), .data_adr(adr), .data_out(wdata), .ext_irq_async(ext),
    .rd_data(rdat[0]), .rd_hit(rhit[0]),
    .machine_software_interrupt(msi_o[0]), .machine_timer_interrupt(mti_o[0]),
    .machine_external_interrupt(mei_o[0])
  );

  clint_timer #(.BASE_ADR(32'h0200_0000), .PRESCALE(P_SLOW)) u_slow (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .data_out_mask(mask), .data_adr(adr), .data_out(wdata), .ext_irq_async(ext),
    .rd_data(rdat[1]), .rd_hit(rhit[1]),
    .machine_software_interrupt(msi_o[1]), .machine_timer_interrupt(mti_o[1]),
    .machine_external_interrupt(mei_o[1])
  );

  // ---------------------------------------------------------------- scoreboard
  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  int unsigned presc [2] = '{P_FAST, P_SLOW};
  logic [63:0] m_time [2];
  logic [63:0] m_cmp  [2];
  logic        m_msip [2];
  int          m_age  [2];   // cycles since the timebase was (re)started
  logic        m_mti  [2];
  logic        m_msi  [2];
  logic        m_mei;
  bit          ext_q[$];     // external line as seen through the synchronizer delay

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n,
                                      input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_rd(input int k, input logic [31:0] a);
    if (a[31:16] != 16'h0200) return 32'd0;
    case ({a[15:2], 2'b00})
      16'h0000: return {31'd0, m_msip[k]};
      16'h4000: return m_cmp[k][31:0];
      16'h4004: return m_cmp[k][63:32];
      16'hBFF8: return m_time[k][31:0];
      16'hBFFC: return m_time[k][63:32];
      default:  return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_time[k] = 64'd0;
      m_cmp[k]  = 64'hFFFF_FFFF_FFFF_FFFF;
      m_msip[k] = 1'b0;
      m_age[k]  = 0;
      m_mti[k]  = 1'b0;
      m_msi[k]  = 1'b0;
    end
    m_mei = 1'b0;
    ext_q.delete();
    ext_q.push_back(1'b0);
  endtask

  task automatic check_outputs();
    logic hit;
    hit = mem_read && (adr[31:16] == 16'h0200);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("p%0d_mti", presc[k]), mti_o[k], m_mti[k]);
      chk($sformatf("p%0d_msi", presc[k]), msi_o[k], m_msi[k]);
      chk($sformatf("p%0d_mei", presc[k]), mei_o[k], m_mei);
      chk($sformatf("p%0d_rd_hit", presc[k]), rhit[k], hit);
      chk($sformatf("p%0d_rd_data@%0h", presc[k], adr), rdat[k],
          hit ? model_rd(k, adr) : 32'd0);
    end
  endtask

  // One clock: compare at the falling edge, advance the model across the rising edge.
  task automatic step();
    logic [63:0] nt [2];
    logic [63:0] nc [2];
    int          na [2];
    logic        nmsip [2];
    logic        nmti [2];
    logic        nmsi [2];
    logic        wr;
    logic [15:0] off;
    bit          nmei;
    @(negedge clk);
    check_outputs();
    wr  = mem_write && (adr[31:16] == 16'h0200);
    off = {adr[15:2], 2'b00};
    for (int k = 0; k < 2; k++) begin
      nt[k] = ((m_age[k] + 1) % presc[k] == 0) ? m_time[k] + 64'd1 : m_time[k];
      na[k] = m_age[k] + 1;
      if (wr && off == 16'hBFF8) begin
        nt[k][31:0] = mrg(m_time[k][31:0], wdata, mask);
        na[k] = 0;
      end
      if (wr && off == 16'hBFFC) begin
        nt[k][63:32] = mrg(m_time[k][63:32], wdata, mask);
        na[k] = 0;
      end
      nc[k] = m_cmp[k];
      if (wr && off == 16'h4000) nc[k][31:0]  = mrg(m_cmp[k][31:0], wdata, mask);
      if (wr && off == 16'h4004) nc[k][63:32] = mrg(m_cmp[k][63:32], wdata, mask);
      nmsip[k] = (wr && off == 16'h0000 && mask[0]) ? wdata[0] : m_msip[k];
      nmti[k]  = (m_time[k] >= m_cmp[k]);
      nmsi[k]  = m_msip[k];
    end
    ext_q.push_back(ext);
    nmei = ext_q.pop_front();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_time[k] = nt[k];
      m_cmp[k]  = nc[k];
      m_age[k]  = na[k];
      m_msip[k] = nmsip[k];
      m_mti[k]  = nmti[k];
      m_msi[k]  = nmsi[k];
    end
    m_mei = nmei;
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic bus_idle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mask      = 4'h0;
    adr       = 32'h0;
    wdata     = 32'h0;
  endtask

  task automatic idle(input int n);
    bus_idle();
    repeat (n) step();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    mem_read  = 1'b0;
    mem_write = 1'b1;
    adr       = 32'h0200_0000 | a;
    wdata     = d;
    mask      = m;
    step();
    bus_idle();
  endtask

  task automatic rd_set(input logic [31:0] a);
    mem_write = 1'b0;
    mem_read  = 1'b1;
    adr       = 32'h0200_0000 | a;
  endtask

  logic [31:0] adr_tab [8] = '{32'h0200_0000, 32'h0200_4000, 32'h0200_4004, 32'h0200_BFF8,
                               32'h0200_BFFC, 32'h0200_0100, 32'h0201_0000, 32'h0200_BFFA};

  initial begin
    #2_000_000;
    n_mis++;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- directed + random sequence
  initial begin
    int guard;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mti", mti_o, 2'b00);
    chk("reset_msi", msi_o, 2'b00);
    chk("reset_mei", mei_o, 2'b00);
    rd_set(32'h4004);
    #1;
    chk("reset_cmp_hi", rdat[0], 32'hFFFF_FFFF);
    bus_idle();
    rst = 1'b1;

    // 40 cycles after reset release: slow timer counted 10, fast timer 40.
    idle(40);
    rd_set(32'hBFF8);
    #2;
    chk("p4_mtime_40cyc", rdat[1], 32'd10);
    chk("p1_mtime_40cyc", rdat[0], 32'd40);
    chk("p4_mti_40cyc", mti_o[1], 1'b0);
    step();
    bus_idle();

    // Timer compare: interrupt rises one cycle after mtime reaches mtimecmp.
    wr(32'hBFFC, 32'd0, 4'hF);
    wr(32'hBFF8, 32'd0, 4'hF);
    wr(32'h4004, 32'd0, 4'hF);
    wr(32'h4000, 32'd20, 4'hF);
    guard = 0;
    while (m_time[0] != 64'd20 && guard < 60) begin
      step();
      guard++;
    end
    chk("wait_mtime20_in_budget", guard < 60, 1'b1);
    #2;
    chk("p1_mti_before_rise", mti_o[0], 1'b0);
    step();
    #2;
    chk("p1_mti_rise", mti_o[0], 1'b1);
    wr(32'h4000, 32'd100, 4'hF);
    step();
    #2;
    chk("p1_mti_fall", mti_o[0], 1'b0);

    // 64-bit carry and byte-masked store during a tick.
    wr(32'hBFF8, 32'hFFFF_FFFF, 4'hF);
    rd_set(32'hBFF8);
    step();
    #2;
    chk("p1_wrap_lo", rdat[0], 32'd0);
    adr = 32'h0200_BFFC;
    #1;
    chk("p1_wrap_hi", rdat[0], 32'd1);
    step();
    wr(32'hBFF8, 32'h0000_00AA, 4'b0001);
    rd_set(32'hBFF8);
    #2;
    chk("p1_bytewr_lo", rdat[0], 32'h0000_00AA);
    adr = 32'h0200_BFFC;
    #1;
    chk("p1_bytewr_hi", rdat[0], 32'd1);
    step();

    // Software interrupt.
    wr(32'h0000, 32'd1, 4'hF);
    #2;
    chk("msi_latency", msi_o, 2'b00);
    rd_set(32'h0000);
    #1;
    chk("msip_read_1", rdat[0], 32'd1);
    step();
    #2;
    chk("msi_set", msi_o, 2'b11);
    wr(32'h0000, 32'hFFFF_FFFE, 4'hF);
    step();
    #2;
    chk("msi_clear", msi_o, 2'b00);
    rd_set(32'h0000);
    #1;
    chk("msip_read_0", rdat[0], 32'd0);
    step();
    bus_idle();

    // External interrupt: 3-cycle pulse, delayed two edges.
    ext = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      if (i == 4) ext = 1'b0;
      step();
      #2;
      chk($sformatf("mei_pulse_%0d", i), mei_o[0], (i >= 2 && i <= 4));
    end

    // Out-of-range read+write: no hit, no state change.
    mem_read  = 1'b1;
    mem_write = 1'b1;
    adr       = 32'h0201_BFF8;
    wdata     = 32'h1234_5678;
    mask      = 4'hF;
    #1;
    chk("oor_rd_hit", rhit, 2'b00);
    chk("oor_rd_data", rdat[0], 32'd0);
    step();
    bus_idle();
    for (int i = 0; i < 8; i++) begin
      mem_read = 1'b1;
      adr = adr_tab[i];
      step();
    end

    // Randomized traffic.
    for (int n = 0; n < 500; n++) begin
      int op;
      int ai;
      op = $urandom_range(0, 3);
      ai = $urandom_range(0, 7);
      mem_read  = op[0];
      mem_write = op[1];
      adr       = adr_tab[ai];
      mask      = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) wdata = 32'($urandom_range(0, 60));
      else                           wdata = $urandom();
      ext       = 1'($urandom_range(0, 1));
      step();
    end
    bus_idle();
    ext = 1'b0;

    // Asynchronous reset with all interrupts active.
    wr(32'h4000, 32'd0, 4'hF);
    wr(32'h4004, 32'd0, 4'hF);
    wr(32'h0000, 32'd1, 4'hF);
    ext = 1'b1;
    idle(3);
    #2;
    chk("pre_rst_mti", mti_o, 2'b11);
    chk("pre_rst_msi", msi_o, 2'b11);
    chk("pre_rst_mei", mei_o, 2'b11);
    rd_set(32'hBFF8);
    rst = 1'b0;
    #1;
    chk("async_rst_mti", mti_o, 2'b00);
    chk("async_rst_msi", msi_o, 2'b00);
    chk("async_rst_mei", mei_o, 2'b00);
    chk("async_rst_mtime_p1", rdat[0], 32'd0);
    chk("async_rst_mtime_p4", rdat[1], 32'd0);
    model_reset();
    ext = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    rd_set(32'hBFF8);
    repeat (8) step();
    bus_idle();
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
